// File: rtl/var_tap_delay.sv
// Multi-channel delay line with a run-time selectable tap and a valid flag that travels with the data.
// The delay is counted in clocks (SAMPLE_MODE=0) or in src_valid_i strobes (SAMPLE_MODE=1).
module var_tap_delay #(
    parameter int DATA_WIDTH    = 16,
    parameter int CH_NUM        = 4,
    parameter int MAX_DELAY     = 32,
    parameter int DEFAULT_DELAY = 2,
    parameter int SAMPLE_MODE   = 0,
    localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DLY_W-1:0]             delay_i,
    input  logic                         delay_load_i,
    input  logic                         src_valid_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0] src_data_i,
    output logic                         delay_valid_o,
    output logic [CH_NUM*DATA_WIDTH-1:0] delay_data_o,
    output logic [DLY_W-1:0]             delay_cur_o,
    output logic                         settled_o
);
    localparam int BUS_W = CH_NUM * DATA_WIDTH;
    localparam int IDX_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DEF_D = DLY_W'(DEFAULT_DELAY);

    logic [DLY_W-1:0]     delay_reg;
    logic [DLY_W-1:0]     delay_next;
    logic [DLY_W-1:0]     fill_reg;
    logic [IDX_W-1:0]     tap_idx;
    logic                 shift_en;
    logic [BUS_W-1:0]     stage_data [MAX_DELAY];
    logic [MAX_DELAY-1:0] stage_valid;
    logic [BUS_W-1:0]     tap_data;
    logic                 tap_valid;

    assign shift_en = (SAMPLE_MODE != 0) ? src_valid_i : 1'b1;

    // Requested delay is clamped into 1..MAX_DELAY so the tap index is always in range.
    always_comb begin
        delay_next = delay_reg;
        if (delay_load_i) begin
            if (delay_i == '0) begin
                delay_next = DLY_W'(1);
            end else if (delay_i > MAX_D) begin
                delay_next = MAX_D;
            end else begin
                delay_next = delay_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            delay_reg <= DEF_D;
        end else begin
            delay_reg <= delay_next;
        end
    end

    // History depth survives delay reloads; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_reg <= '0;
        end else if (shift_en && (fill_reg != MAX_D)) begin
            fill_reg <= fill_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_stage
        logic [BUS_W-1:0] data_reg;
        logic             valid_reg;
        logic [BUS_W-1:0] data_in;
        logic             valid_in;

        if (gi == 0) begin : g_head
            assign data_in  = src_data_i;
            assign valid_in = src_valid_i;
        end else begin : g_body
            assign data_in  = stage_data[gi-1];
            assign valid_in = stage_valid[gi-1];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (shift_en) begin
                data_reg  <= data_in;
                valid_reg <= valid_in;
            end
        end

        assign stage_data[gi]  = data_reg;
        assign stage_valid[gi] = valid_reg;
    end

    assign tap_idx   = IDX_W'(delay_reg - 1'b1);
    assign tap_data  = stage_data[tap_idx];
    assign tap_valid = stage_valid[tap_idx];

    if (SAMPLE_MODE != 0) begin : g_sample
        logic [BUS_W-1:0] out_data_reg;
        logic             out_valid_reg;

        // Tap is read before this edge's shift, so a strobe returns the sample from D strobes ago.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                out_data_reg  <= '0;
                out_valid_reg <= 1'b0;
            end else if (src_valid_i) begin
                out_data_reg  <= tap_data;
                out_valid_reg <= (fill_reg >= delay_reg);
            end else begin
                out_valid_reg <= 1'b0;
            end
        end

        assign delay_data_o  = out_data_reg;
        assign delay_valid_o = out_valid_reg;
    end else begin : g_cycle
        assign delay_data_o  = tap_data;
        assign delay_valid_o = tap_valid;
    end

    assign delay_cur_o = delay_reg;
    assign settled_o   = (fill_reg >= delay_reg);

endmodule
